bus_mux_reg: RTL
================

Name: bus_mux_reg

Overview:
- Parametrised successor to the datapath bus multiplexer: NUM_SRC sources of WIDTH bits, selected by per-source out-enables, with lowest index winning.
- Adds a bus keeper: the bus holds the last driven value when no source drives it, so the output never floats and no latch is inferred.
- Adds a registered bus copy, a registered driver index, and contention detection with a sticky flag and a saturating counter.
- Sits between the register file, special registers (MDR, HI, LO, Z, PC, InPort, C) and every bus consumer.

Parameters:
- WIDTH, 32, bus and per-source data width.
- NUM_SRC, 24, number of bus sources.
- PRIORITY_MODE, 1: 1 = on contention the lowest asserted index drives the bus; 0 = on contention the bus is forced to 0 and the keeper is not updated.
- CNT_W, 8, width of the contention counter.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous active-low reset.
- src_out  in  NUM_SRC  per-source out-enable; bit i selects source i.
- src_data  in  NUM_SRC*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH].
- err_clr  in  1  synchronous clear of err_sticky and err_count.
- bus_out  out  WIDTH  combinational bus value, the same-cycle result.
- bus_q  out  WIDTH  bus_out registered.
- bus_valid  out  1  registered; 1 if any src_out bit was asserted in the previous cycle.
- drv_idx  out  max(1,$clog2(NUM_SRC))  registered index of the source that drove the bus.
- contention  out  1  combinational; more than one src_out bit asserted.
- err_sticky  out  1  registered; set on any contention, held until err_clr.
- err_count  out  CNT_W  registered count of contention cycles, saturating.

Behaviour:
- Reset (clear=0, asynchronous):
  - keeper, bus_q, drv_idx, err_count cleared to 0.
  - bus_valid, err_sticky cleared to 0.
  - bus_out follows the combinational rules with keeper=0.
- Selection (combinational):
  - win = lowest i with src_out[i]=1.
  - any = |src_out.
  - contention = (popcount(src_out) > 1).
- bus_out:
  - any=0: keeper.
  - any=1, contention=0: src_data[win].
  - contention=1, PRIORITY_MODE=1: src_data[win].
  - contention=1, PRIORITY_MODE=0: 0.
- Keeper register, updated on the rising edge:
  - Loads bus_out when any=1, except under contention with PRIORITY_MODE=0.
  - Otherwise holds.
- Registered outputs, updated every rising edge:
  - bus_q <= bus_out.
  - bus_valid <= any.
  - drv_idx <= win when any=1; holds otherwise.
  - Under contention with PRIORITY_MODE=0, drv_idx still loads win.
- Error logic:
  - err_clr=1: err_sticky <= 0 and err_count <= 0. err_clr takes precedence over a contention in the same cycle, which is not counted.
  - Else if contention=1: err_sticky <= 1; err_count <= err_count+1, saturating at 2^CNT_W-1 (no wrap).
- Latency:
  - bus_out: 0 cycles.
  - bus_q, bus_valid, drv_idx, err_*: 1 cycle.
- Reset mid-operation:
  - All registers clear immediately, without waiting for a clock edge.
  - The first edge after clear is released behaves as a normal cycle.
- Data width:
  - No arithmetic on data; sources pass through bit-exact.
  - drv_idx is zero-extended from the index value.

Test Plan:
1. Reset, then src_out=0 -> bus_out=0; after an edge bus_q=0, bus_valid=0, err_sticky=0, err_count=0.
2. src_out[3]=1 with src_data[3]=0xB6 for one cycle, then src_out=0 for 3 cycles -> bus_out=0xB6 in the drive cycle; bus_q=0xB6 and drv_idx=3, bus_valid=1 after edge 1; bus_out and bus_q stay 0xB6 with bus_valid=0 afterwards (keeper).
3. PRIORITY_MODE=1, src_out bits 6 and 8 set, src_data[6]=0x84, src_data[8]=0xB6 -> bus_out=0x84, contention=1; next edge drv_idx=6, err_sticky=1, err_count=1.
4. PRIORITY_MODE=0, keeper=0x55, src_out bits 0 and 1 set -> bus_out=0, keeper not updated; src_out=0 next cycle -> bus_out=0x55; err_count increments by 1.
5. CNT_W=2, 5 consecutive contention cycles -> err_count sequence 1,2,3,3,3. Then err_clr=1 together with contention -> err_count=0, err_sticky=0.
6. Drive src 23 with 0xDEADBEEF, then assert clear asynchronously between clock edges -> bus_q, keeper and drv_idx go to 0 before the next edge; bus_out=0 while src_out=0.

Source files
------------

// File: rtl/bus_mux_reg_if.sv
// Bus multiplexer port bundle: source enables/data in, bus copies and
// contention status out.
interface bus_mux_reg_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 24,
  parameter int CNT_W   = 8
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]       src_out;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic                     err_clr;
  logic [WIDTH-1:0]         bus_out;
  logic [WIDTH-1:0]         bus_q;
  logic                     bus_valid;
  logic [IW-1:0]            drv_idx;
  logic                     contention;
  logic                     err_sticky;
  logic [CNT_W-1:0]         err_count;

  modport master (
    output src_out, src_data, err_clr,
    input  bus_out, bus_q, bus_valid, drv_idx,
    input  contention, err_sticky, err_count
  );

  modport slave (
    input  src_out, src_data, err_clr,
    output bus_out, bus_q, bus_valid, drv_idx,
    output contention, err_sticky, err_count
  );
endinterface

// File: rtl/bus_mux_reg.sv
// Priority bus multiplexer with keeper, registered bus copy and
// contention tracking (sticky flag plus saturating counter).
module bus_mux_reg #(
  parameter int WIDTH         = 32,
  parameter int NUM_SRC       = 24,
  parameter int PRIORITY_MODE = 1,
  parameter int CNT_W         = 8
) (
  input  logic         clock,
  input  logic         clear,
  bus_mux_reg_if.slave bus
);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [IW-1:0]    win;
  logic [WIDTH-1:0] sel;
  logic [WIDTH-1:0] keeper;
  logic [WIDTH-1:0] bus_nx;
  logic             any;
  logic             cont;
  logic             drop;

  // Descending scan so the lowest asserted index is written last.
  always_comb begin
    win = '0;
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.src_out[i]) begin
        win = IW'(i);
        sel = bus.src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign any  = |bus.src_out;
  assign cont = (bus.src_out & (bus.src_out - 1'b1)) != '0;
  assign drop = cont && (PRIORITY_MODE == 0);

  always_comb begin
    bus_nx = keeper;
    if (any) bus_nx = drop ? '0 : sel;
  end

  assign bus.bus_out    = bus_nx;
  assign bus.contention = cont;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      keeper        <= '0;
      bus.bus_q     <= '0;
      bus.bus_valid <= 1'b0;
      bus.drv_idx   <= '0;
    end else begin
      if (any && !drop) keeper <= bus_nx;
      bus.bus_q     <= bus_nx;
      bus.bus_valid <= any;
      if (any) bus.drv_idx <= win;
    end
  end

  // Clear wins over a same-cycle contention, which is then not counted.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus.err_sticky <= 1'b0;
      bus.err_count  <= '0;
    end else if (bus.err_clr) begin
      bus.err_sticky <= 1'b0;
      bus.err_count  <= '0;
    end else if (cont) begin
      bus.err_sticky <= 1'b1;
      if (bus.err_count != '1)
        bus.err_count <= bus.err_count + 1'b1;
    end
  end
endmodule
